windowed_reg_file_spill: RTL and testbench

Parametrised overlapping-window register file: two combinational read ports and one write port, addressed relative to a current window pointer (cwp). Adds save/restore window stepping with automatic spill/fill of the oldest resident window to an external backing store over a req/ack handshake. Sits between the datapath register-address decode and the data-memory arbiter; successor to the fixed 8x16, 4-window file.

---
 rtl/windowed_reg_file_spill.sv | 270 +++++++++++++++++++++++++++
 tb/tb_windowed_reg_file_spill.sv | 501 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/windowed_reg_file_spill.sv
// -----------------------------------------------------------------------------
// windowed_reg_file_spill
//
// Overlapping-window register file with two combinational read ports and one
// write port, all addressed relative to the current window pointer (cwp).
// Logical register r in window w lives at physical register
// (w*STRIDE + r) mod P, so the low half of window w aliases the high half of
// window w-1. The save/restore commands step the window. When every physical
// window is occupied, the oldest resident window is spilled to an external
// backing store; when returning past the last resident caller, a window is
// filled back. Both transfers use a req/ack handshake.
//
// Optional build macro:
//   WINREG_BYPASS_EN - an accepted write forwards wr_data to any read port
//                      addressing the same physical register in that cycle.
//
// Ports:
//   clk, rst             clock (posedge) and asynchronous active-high reset
//   rd_i, rd_j           logical read addresses
//   rd_data_i, rd_data_j combinational read data
//   wr_en, wr_addr,
//   wr_data              write strobe, logical address and data (IDLE only)
//   save, restore,
//   set_wnd, wnd         window commands (IDLE only, set_wnd > save > restore)
//   cwp                  current window pointer
//   busy                 high while a spill or fill is running
//   err                  one-cycle pulse on window overflow/underflow
//   mem_req, mem_we,
//   mem_addr, mem_wdata  backing-store request (registered)
//   mem_ack, mem_rdata   backing-store acknowledge and fill data
// -----------------------------------------------------------------------------
module windowed_reg_file_spill #(
    parameter int DATA_W    = 16,
    parameter int NWIN      = 4,
    parameter int STRIDE    = 2,
    parameter int MAX_SPILL = 4,
    parameter int AW        = $clog2(MAX_SPILL * STRIDE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(2*STRIDE)-1:0]   rd_i,
    input  logic [$clog2(2*STRIDE)-1:0]   rd_j,
    output logic [DATA_W-1:0]             rd_data_i,
    output logic [DATA_W-1:0]             rd_data_j,
    input  logic                          wr_en,
    input  logic [$clog2(2*STRIDE)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          save,
    input  logic                          restore,
    input  logic                          set_wnd,
    input  logic [$clog2(NWIN)-1:0]       wnd,
    output logic [$clog2(NWIN)-1:0]       cwp,
    output logic                          busy,
    output logic                          err,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [AW-1:0]                 mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_ack,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int P    = NWIN * STRIDE;
    localparam int WW   = $clog2(NWIN);
    localparam int PW   = (P > 1) ? $clog2(P) : 1;
    localparam int DW   = $clog2(MAX_SPILL + 1);
    localparam int KW   = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int RESW = $clog2(NWIN - 1);

    typedef enum logic [1:0] {
        IDLE,
        SPILL,
        FILL
    } state_t;

    state_t              state_q, state_d;
    logic [WW-1:0]       cwp_q, cwp_d;
    logic [RESW-1:0]     res_q, res_d;
    logic [DW-1:0]       depth_q, depth_d;
    logic [KW-1:0]       k_q, k_d;
    logic                err_q, err_d;
    logic                memReq_q, memReq_d;
    logic                memWe_q, memWe_d;
    logic [AW-1:0]       memAddr_q, memAddr_d;
    logic [DATA_W-1:0]   memWdata_q, memWdata_d;

    logic [DATA_W-1:0]   regs_q [P];

    logic                wrAccept;
    logic [PW-1:0]       wrIdx;
    logic                regWe;
    logic [PW-1:0]       regWaddr;
    logic [DATA_W-1:0]   regWdata;
    logic [WW-1:0]       oldest;
    logic [PW-1:0]       rdIdxI, rdIdxJ;

    // Window-relative to physical register translation; window arithmetic
    // wraps naturally because NWIN is a power of two.
    function automatic logic [PW-1:0] physIdx(input logic [WW-1:0] w, input int r);
        int t;
        t = (int'(w) * STRIDE + r) % P;
        return PW'(t);
    endfunction

    // Backing-store word address of word k inside spilled block blk.
    function automatic logic [AW-1:0] memAddrOf(input int blk, input int k);
        return AW'(blk * STRIDE + k);
    endfunction

    assign wrAccept = wr_en && (state_q == IDLE);
    assign wrIdx    = physIdx(cwp_q, int'(wr_addr));
    // Oldest resident window sits NWIN-2 steps behind the current one.
    assign oldest   = cwp_q - WW'(NWIN - 2);
    assign rdIdxI   = physIdx(cwp_q, int'(rd_i));
    assign rdIdxJ   = physIdx(cwp_q, int'(rd_j));

`ifdef WINREG_BYPASS_EN
    assign rd_data_i = (wrAccept && (wrIdx == rdIdxI)) ? wr_data : regs_q[rdIdxI];
    assign rd_data_j = (wrAccept && (wrIdx == rdIdxJ)) ? wr_data : regs_q[rdIdxJ];
`else
    assign rd_data_i = regs_q[rdIdxI];
    assign rd_data_j = regs_q[rdIdxJ];
`endif

    assign cwp       = cwp_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;
    assign mem_req   = memReq_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;

    // Next-state logic: commands only in IDLE; a spill or fill walks through
    // STRIDE words, advancing one word per acknowledge, and only moves the
    // window pointer once the last word has been transferred.
    always_comb begin
        state_d    = state_q;
        cwp_d      = cwp_q;
        res_d      = res_q;
        depth_d    = depth_q;
        k_d        = k_q;
        err_d      = 1'b0;
        memReq_d   = memReq_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        regWe      = 1'b0;
        regWaddr   = wrIdx;
        regWdata   = wr_data;

        case (state_q)
            IDLE: begin
                regWe = wrAccept;
                if (set_wnd) begin
                    cwp_d   = wnd;
                    res_d   = '0;
                    depth_d = '0;
                end else if (save) begin
                    if (res_q < RESW'(NWIN - 2)) begin
                        cwp_d = cwp_q + WW'(1);
                        res_d = res_q + RESW'(1);
                    end else if (depth_q < DW'(MAX_SPILL)) begin
                        state_d    = SPILL;
                        k_d        = '0;
                        memReq_d   = 1'b1;
                        memWe_d    = 1'b1;
                        memAddr_d  = memAddrOf(int'(depth_q), 0);
                        memWdata_d = regs_q[physIdx(oldest, 0)];
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (restore) begin
                    if (res_q != '0) begin
                        cwp_d = cwp_q - WW'(1);
                        res_d = res_q - RESW'(1);
                    end else if (depth_q != '0) begin
                        state_d   = FILL;
                        k_d       = '0;
                        memReq_d  = 1'b1;
                        memWe_d   = 1'b0;
                        memAddr_d = memAddrOf(int'(depth_q) - 1, 0);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            SPILL: begin
                if (mem_ack) begin
                    if (k_q == KW'(STRIDE - 1)) begin
                        state_d  = IDLE;
                        memReq_d = 1'b0;
                        k_d      = '0;
                        cwp_d    = cwp_q + WW'(1);
                        depth_d  = depth_q + DW'(1);
                    end else begin
                        k_d        = k_q + KW'(1);
                        memAddr_d  = memAddrOf(int'(depth_q), int'(k_q) + 1);
                        memWdata_d = regs_q[physIdx(oldest, int'(k_q) + 1)];
                    end
                end
            end

            FILL: begin
                if (mem_ack) begin
                    // Refilled window is the one just below the current window.
                    regWe    = 1'b1;
                    regWaddr = physIdx(cwp_q - WW'(1), int'(k_q));
                    regWdata = mem_rdata;
                    if (k_q == KW'(STRIDE - 1)) begin
                        state_d  = IDLE;
                        memReq_d = 1'b0;
                        k_d      = '0;
                        cwp_d    = cwp_q - WW'(1);
                        depth_d  = depth_q - DW'(1);
                    end else begin
                        k_d       = k_q + KW'(1);
                        memAddr_d = memAddrOf(int'(depth_q) - 1, int'(k_q) + 1);
                    end
                end
            end

            default: begin
                state_d  = IDLE;
                memReq_d = 1'b0;
            end
        endcase
    end

    // Control and backing-store interface registers; reset aborts any
    // transfer in flight and drops mem_req immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cwp_q      <= '0;
            res_q      <= '0;
            depth_q    <= '0;
            k_q        <= '0;
            err_q      <= 1'b0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cwp_q      <= cwp_d;
            res_q      <= res_d;
            depth_q    <= depth_d;
            k_q        <= k_d;
            err_q      <= err_d;
            memReq_q   <= memReq_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
        end
    end

    // Physical register array: single write port shared by datapath writes
    // (IDLE) and fill data (FILL).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < P; i++) begin
                regs_q[i] <= '0;
            end
        end else if (regWe) begin
            regs_q[regWaddr] <= regWdata;
        end
    end

endmodule

// File: tb/tb_windowed_reg_file_spill.sv
// -----------------------------------------------------------------------------
// tb_windowed_reg_file_spill
//
// Directed bench for windowed_reg_file_spill with the default parameters
// (DATA_W=16, NWIN=4, STRIDE=2, MAX_SPILL=4, AW=3). A small backing-store
// model answers mem_req after a programmable number of idle cycles and logs
// every spill word it accepts.
// -----------------------------------------------------------------------------
module tb_windowed_reg_file_spill;

    localparam int DATA_W    = 16;
    localparam int NWIN      = 4;
    localparam int STRIDE    = 2;
    localparam int MAX_SPILL = 4;
    localparam int AW        = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        rd_i, rd_j;
    logic [15:0]       rd_data_i, rd_data_j;
    logic              wr_en;
    logic [1:0]        wr_addr;
    logic [15:0]       wr_data;
    logic              save, restore, set_wnd;
    logic [1:0]        wnd;
    logic [1:0]        cwp;
    logic              busy, err;
    logic              mem_req, mem_we;
    logic [AW-1:0]     mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ack;
    logic [15:0]       mem_rdata;

    int checks = 0;
    int errors = 0;

    // Backing-store model state
    logic [15:0]   bsMem [8];
    int            ackDelay = 0;
    int            waitCnt  = 0;
    int            wrCount  = 0;
    logic [AW-1:0] wrLogAddr [16];
    logic [15:0]   wrLogData [16];

    windowed_reg_file_spill #(
        .DATA_W(DATA_W), .NWIN(NWIN), .STRIDE(STRIDE),
        .MAX_SPILL(MAX_SPILL), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_i(rd_i), .rd_j(rd_j),
        .rd_data_i(rd_data_i), .rd_data_j(rd_data_j),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .save(save), .restore(restore), .set_wnd(set_wnd), .wnd(wnd),
        .cwp(cwp), .busy(busy), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Backing store: acknowledge each requested word after ackDelay cycles.
    always @(negedge clk) begin
        if (mem_req && !rst) begin
            if (waitCnt >= ackDelay) begin
                mem_ack   = 1'b1;
                mem_rdata = bsMem[mem_addr];
                if (mem_we) begin
                    bsMem[mem_addr] = mem_wdata;
                    if (wrCount < 16) begin
                        wrLogAddr[wrCount] = mem_addr;
                        wrLogData[wrCount] = mem_wdata;
                    end
                    wrCount++;
                end
                waitCnt = 0;
            end else begin
                mem_ack = 1'b0;
                waitCnt++;
            end
        end else begin
            mem_ack = 1'b0;
            waitCnt = 0;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic stepClock();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pulse window commands for exactly one clock edge.
    task automatic applyStimulus(input logic doSave, input logic doRestore,
                                 input logic doSetWnd, input logic [1:0] w);
        save    = doSave;
        restore = doRestore;
        set_wnd = doSetWnd;
        wnd     = w;
        stepClock();
        save    = 1'b0;
        restore = 1'b0;
        set_wnd = 1'b0;
    endtask

    task automatic doWrite(input logic [1:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        stepClock();
        wr_en   = 1'b0;
    endtask

    task automatic doReset();
        rst     = 1'b1;
        wr_en   = 1'b0;
        save    = 1'b0;
        restore = 1'b0;
        set_wnd = 1'b0;
        wnd     = '0;
        rd_i    = '0;
        rd_j    = '0;
        repeat (2) stepClock();
        rst     = 1'b0;
        wrCount = 0;
    endtask

    task automatic waitIdle(output int cnt);
        cnt = 0;
        while (busy && cnt < 50) begin
            stepClock();
            cnt++;
        end
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if ({cwp, busy, err, mem_req, mem_we} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got cwp=%0d busy=%b err=%b req=%b we=%b, expected all 0",
                     cwp, busy, err, mem_req, mem_we);
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 19'h0) begin
            errors++;
            $display("[TB] FAIL reset_mem: got addr=%h wdata=%h, expected 0/0", mem_addr, mem_wdata);
        end
        doWrite(2'd1, 16'h1111);
        rd_i = 2'd1;
        #1;
        checks++;
        if (rd_data_i !== 16'h1111) begin
            errors++;
            $display("[TB] FAIL reset_r1: got %h expected 1111", rd_data_i);
        end
        for (int r = 0; r < 4; r++) begin
            if (r != 1) begin
                rd_j = 2'(r);
                #1;
                checks++;
                if (rd_data_j !== 16'h0000) begin
                    errors++;
                    $display("[TB] FAIL reset_w0_r%0d: got %h expected 0000", r, rd_data_j);
                end
            end
        end
        // Window 2 exposes physical registers 4..7.
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd2);
        checks++;
        if (cwp !== 2'd2) begin
            errors++;
            $display("[TB] FAIL reset_setwnd: got cwp=%0d expected 2", cwp);
        end
        for (int r = 0; r < 4; r++) begin
            rd_j = 2'(r);
            #1;
            checks++;
            if (rd_data_j !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL reset_w2_r%0d: got %h expected 0000", r, rd_data_j);
            end
        end
    endtask

    task automatic test_overlap();
        doReset();
        doWrite(2'd2, 16'hAAAA);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        checks++;
        if (cwp !== 2'd1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overlap_save: got cwp=%0d busy=%b expected 1/0", cwp, busy);
        end
        rd_i = 2'd0;
        rd_j = 2'd1;
        #1;
        checks++;
        if (rd_data_i !== 16'hAAAA) begin
            errors++;
            $display("[TB] FAIL overlap_r0: got %h expected aaaa", rd_data_i);
        end
        checks++;
        if (rd_data_j !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL overlap_r1: got %h expected 0000", rd_data_j);
        end
    endtask

    task automatic test_set_wnd_priority();
        doReset();
        // set_wnd wins over save and restore
        save = 1'b1;
        restore = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd3);
        checks++;
        if (cwp !== 2'd3) begin
            errors++;
            $display("[TB] FAIL prio_setwnd: got cwp=%0d expected 3", cwp);
        end
        // save wins over restore
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
        checks++;
        if (cwp !== 2'd0) begin
            errors++;
            $display("[TB] FAIL prio_save_wrap: got cwp=%0d expected 0", cwp);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
        checks++;
        if (err !== 1'b1 || cwp !== 2'd3) begin
            errors++;
            $display("[TB] FAIL prio_underflow: got err=%b cwp=%0d expected 1/3", err, cwp);
        end
    endtask

    task automatic test_spill();
        int cnt;
        doReset();
        ackDelay = 2;
        doWrite(2'd0, 16'h0A00);
        doWrite(2'd1, 16'h0A01);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        checks++;
        if ({busy, mem_req, mem_we} !== 3'b111 || mem_addr !== 3'd0 || mem_wdata !== 16'h0A00) begin
            errors++;
            $display("[TB] FAIL spill_start: got busy=%b req=%b we=%b addr=%0d wdata=%h expected 1/1/1/0/0a00",
                     busy, mem_req, mem_we, mem_addr, mem_wdata);
        end
        // A write while busy must be dropped (window 2 r0 = phys4).
        wr_en   = 1'b1;
        wr_addr = 2'd0;
        wr_data = 16'hDEAD;
        cnt = 0;
        while (busy && cnt < 50) begin
            stepClock();
            wr_en = 1'b0;
            cnt++;
        end
        checks++;
        if (cnt !== 6) begin
            errors++;
            $display("[TB] FAIL spill_busy_cycles: got %0d expected 6", cnt);
        end
        checks++;
        if (cwp !== 2'd3 || mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL spill_end: got cwp=%0d req=%b expected 3/0", cwp, mem_req);
        end
        checks++;
        if (wrCount !== 2) begin
            errors++;
            $display("[TB] FAIL spill_count: got %0d expected 2", wrCount);
        end
        checks++;
        if (wrLogAddr[0] !== 3'd0 || wrLogData[0] !== 16'h0A00 ||
            wrLogAddr[1] !== 3'd1 || wrLogData[1] !== 16'h0A01) begin
            errors++;
            $display("[TB] FAIL spill_words: got %0d:%h %0d:%h expected 0:0a00 1:0a01",
                     wrLogAddr[0], wrLogData[0], wrLogAddr[1], wrLogData[1]);
        end
    endtask

    // Continues from test_spill: cwp=3, two resident callers, one spilled.
    task automatic test_fill();
        int cnt;
        ackDelay = 0;
        doWrite(2'd2, 16'h5555);
        doWrite(2'd3, 16'h6666);
        rd_i = 2'd2;
        #1;
        checks++;
        if (rd_data_i !== 16'h5555) begin
            errors++;
            $display("[TB] FAIL fill_clobber: got %h expected 5555", rd_data_i);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
        rd_i = 2'd0;
        #1;
        checks++;
        if (cwp !== 2'd2 || rd_data_i !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL fill_busy_write: got cwp=%0d r0=%h expected 2/0000", cwp, rd_data_i);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
        checks++;
        if ({busy, mem_req, mem_we} !== 3'b110 || mem_addr !== 3'd0) begin
            errors++;
            $display("[TB] FAIL fill_start: got busy=%b req=%b we=%b addr=%0d expected 1/1/0/0",
                     busy, mem_req, mem_we, mem_addr);
        end
        waitIdle(cnt);
        checks++;
        if (cnt !== 2) begin
            errors++;
            $display("[TB] FAIL fill_cycles: got %0d expected 2", cnt);
        end
        rd_i = 2'd0;
        rd_j = 2'd1;
        #1;
        checks++;
        if (cwp !== 2'd0 || rd_data_i !== 16'h0A00 || rd_data_j !== 16'h0A01) begin
            errors++;
            $display("[TB] FAIL fill_data: got cwp=%0d r0=%h r1=%h expected 0/0a00/0a01",
                     cwp, rd_data_i, rd_data_j);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
        checks++;
        if (err !== 1'b1 || cwp !== 2'd0 || mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill_depth0: got err=%b cwp=%0d req=%b expected 1/0/0", err, cwp, mem_req);
        end
    endtask

    task automatic test_underflow();
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
        checks++;
        if (err !== 1'b1 || cwp !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL underflow_pulse: got err=%b cwp=%0d busy=%b expected 1/0/0", err, cwp, busy);
        end
        stepClock();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL underflow_width: got err=%b expected 0", err);
        end
    endtask

    task automatic test_overflow();
        int cnt;
        doReset();
        ackDelay = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
            waitIdle(cnt);
            checks++;
            if (cnt !== 2) begin
                errors++;
                $display("[TB] FAIL overflow_spill%0d: got %0d cycles expected 2", s, cnt);
            end
        end
        checks++;
        if (cwp !== 2'd2 || wrCount !== 8 || wrLogAddr[7] !== 3'd7) begin
            errors++;
            $display("[TB] FAIL overflow_fill_up: got cwp=%0d count=%0d last=%0d expected 2/8/7",
                     cwp, wrCount, wrLogAddr[7]);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        checks++;
        if (err !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b0 || cwp !== 2'd2) begin
            errors++;
            $display("[TB] FAIL overflow_err: got err=%b req=%b busy=%b cwp=%0d expected 1/0/0/2",
                     err, mem_req, busy, cwp);
        end
        stepClock();
        checks++;
        if (err !== 1'b0 || wrCount !== 8) begin
            errors++;
            $display("[TB] FAIL overflow_after: got err=%b count=%0d expected 0/8", err, wrCount);
        end
    endtask

    task automatic test_reset_mid_spill();
        doReset();
        ackDelay = 0;
        doWrite(2'd0, 16'h0A00);
        doWrite(2'd1, 16'h0A01);
        doWrite(2'd3, 16'h1234);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        stepClock();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 3'd1 || mem_wdata !== 16'h0A01) begin
            errors++;
            $display("[TB] FAIL midspill_word1: got req=%b addr=%0d wdata=%h expected 1/1/0a01",
                     mem_req, mem_addr, mem_wdata);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || cwp !== 2'd0) begin
            errors++;
            $display("[TB] FAIL midspill_abort: got req=%b busy=%b cwp=%0d expected 0/0/0", mem_req, busy, cwp);
        end
        for (int r = 0; r < 4; r++) begin
            rd_i = 2'(r);
            #1;
            checks++;
            if (rd_data_i !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL midspill_r%0d: got %h expected 0000", r, rd_data_i);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        stepClock();
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || cwp !== 2'd0) begin
            errors++;
            $display("[TB] FAIL midspill_after: got req=%b busy=%b cwp=%0d expected 0/0/0", mem_req, busy, cwp);
        end
    endtask

    task automatic test_bypass();
        logic [15:0] expSame;
        doReset();
`ifdef WINREG_BYPASS_EN
        expSame = 16'hBEEF;
`else
        expSame = 16'h0000;
`endif
        wr_en   = 1'b1;
        wr_addr = 2'd3;
        wr_data = 16'hBEEF;
        rd_i    = 2'd3;
        rd_j    = 2'd2;
        #1;
        checks++;
        if (rd_data_i !== expSame) begin
            errors++;
            $display("[TB] FAIL bypass_same: got %h expected %h", rd_data_i, expSame);
        end
        checks++;
        if (rd_data_j !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL bypass_other: got %h expected 0000", rd_data_j);
        end
        stepClock();
        wr_en = 1'b0;
        #1;
        checks++;
        if (rd_data_i !== 16'hBEEF) begin
            errors++;
            $display("[TB] FAIL bypass_after: got %h expected beef", rd_data_i);
        end
    endtask

    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        save      = 1'b0;
        restore   = 1'b0;
        set_wnd   = 1'b0;
        wnd       = '0;
        rd_i      = '0;
        rd_j      = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 8; i++) bsMem[i] = '0;
        @(negedge clk);

        $display("[TB] starting windowed_reg_file_spill bench");
        test_reset();
        test_overlap();
        test_set_wnd_priority();
        test_spill();
        test_fill();
        test_underflow();
        test_overflow();
        test_reset_mid_spill();
        test_bypass();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
